network_mul_arb_16s_14s: RTL and testbench

NETWORK_MUL_ARB_16S_14S -- requirements
Module: network_mul_arb_16s_14s

---
 rtl/network_mul_arb_16s_14s.sv | 120 ++++++++++++
 tb/tb_network_mul_arb_16s_14s.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_mul_arb_16s_14s.sv
// Round-robin arbiter in front of a shared two-stage signed 16x14 multiplier.
// Ports:
//   ap_clk, ap_rst           clock, synchronous active-high reset
//   req_valid/req_a/req_b    per-requester operand pairs (a: 16b signed, b: 14b signed)
//   req_ready                combinational one-hot grant (accept = valid & ready)
//   res_valid/res_ready      result handshake
//   res_data/res_id          30-bit signed product and the requester it belongs to
module network_mul_arb_16s_14s #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [14*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [29:0]          res_data,
    output logic [ID_W-1:0]      res_id
);

    localparam int unsigned A_W  = 16;
    localparam int unsigned B_W  = 14;
    localparam int unsigned P_W  = A_W + B_W;
    localparam int          NREQ_I = int'(NREQ);

    logic [ID_W-1:0]       rr_ptr;
    logic                  s1_valid;
    logic signed [A_W-1:0] s1_a;
    logic signed [B_W-1:0] s1_b;
    logic [ID_W-1:0]       s1_id;
    logic                  s2_valid;
    logic [P_W-1:0]        s2_data;
    logic [ID_W-1:0]       s2_id;

    logic                  s2_adv;
    logic                  s1_adv;
    logic                  any_valid;
    logic                  accept;
    logic [NREQ-1:0]       gnt_oh;
    logic [ID_W-1:0]       gnt_id;
    logic [ID_W-1:0]       rr_next;
    logic [A_W-1:0]        sel_a;
    logic [B_W-1:0]        sel_b;

    assign s2_adv = !s2_valid || res_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // Round-robin pick: the valid requester with the smallest distance from rr_ptr wins.
    always_comb begin
        int best_idx;
        int best_off;
        int off;
        best_idx = 0;
        best_off = NREQ_I;
        off      = 0;
        gnt_oh   = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NREQ_I; i++) begin
            off = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NREQ_I - int'(rr_ptr));
            if (req_valid[i] && (off < best_off)) begin
                best_off = off;
                best_idx = i;
            end
        end
        any_valid = (best_off < NREQ_I);
        gnt_id    = ID_W'(best_idx);
        // Only the granted requester's operands reach the S1 load mux.
        for (int i = 0; i < NREQ_I; i++) begin
            if (any_valid && (best_idx == i)) begin
                gnt_oh[i] = 1'b1;
                sel_a     = req_a[A_W*i +: A_W];
                sel_b     = req_b[B_W*i +: B_W];
            end
        end
    end

    assign req_ready = (s1_adv && !ap_rst) ? gnt_oh : '0;
    assign accept    = any_valid && s1_adv && !ap_rst;
    assign rr_next   = (gnt_id == ID_W'(NREQ - 1)) ? '0 : (gnt_id + ID_W'(1));

    // S1 captures the granted pair; S2 holds the full-precision product.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= P_W'(s1_a) * P_W'(s1_b);
                    s2_id   <= s1_id;
                end
            end
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_a   <= sel_a;
                    s1_b   <= sel_b;
                    s1_id  <= gnt_id;
                    rr_ptr <= rr_next;
                end
            end
        end
    end

    assign res_valid = s2_valid;
    assign res_data  = s2_data;
    assign res_id    = s2_id;

endmodule

// File: tb/tb_network_mul_arb_16s_14s.sv
module tb_network_mul_arb_16s_14s;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic [NREQ-1:0]     req_valid;
    logic [16*NREQ-1:0]  req_a;
    logic [14*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic                res_ready;
    logic [29:0]         res_data;
    logic [ID_W-1:0]     res_id;

    network_mul_arb_16s_14s #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    always #5 ap_clk = ~ap_clk;

    int vecs = 0;
    int miscompares = 0;

    // Reference model: round-robin pointer, pipeline occupancy, expected result order.
    int          rr_m = 0;
    int          n_m  = 0;
    logic [29:0] q_data[$];
    int          q_id[$];
    logic        prev_stall = 1'b0;
    logic [29:0] prev_data;
    logic [ID_W-1:0] prev_id;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [13:0] b;
        logic [29:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Two slots in the pipeline; a new pair fits if one is free or the output drains.
    function automatic int model_grant();
        int idx;
        if (!(n_m < 2 || res_ready)) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (rr_m + k) % NREQ;
            if (req_valid[ID_W'(idx)]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [29:0] prod(input int idx);
        int pa;
        int pb;
        pa = int'($signed(16'(req_a >> (16 * idx))));
        pb = int'($signed(14'(req_b >> (14 * idx))));
        return 30'(pa * pb);
    endfunction

    task automatic model_clear();
        rr_m = 0;
        n_m  = 0;
        q_data.delete();
        q_id.delete();
        prev_stall = 1'b0;
    endtask

    // One clock: check grant and output against the model, then advance. Called at negedge.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic pop;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[ID_W'(g)] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (prev_stall) begin
            chk("hold_data", 64'(res_data), 64'(prev_data));
            chk("hold_id", 64'(res_id), 64'(prev_id));
        end
        pop = res_valid && res_ready;
        if (pop) begin
            if (q_data.size() == 0) begin
                vecs++;
                miscompares++;
                $display("FAIL unexpected_result: got id %0d data %0h expected none", res_id, res_data);
            end else begin
                chk("res_data", 64'(res_data), 64'(q_data.pop_front()));
                chk("res_id", 64'(res_id), 64'(q_id.pop_front()));
            end
            n_m--;
        end
        prev_stall = res_valid && !res_ready;
        prev_data  = res_data;
        prev_id    = res_id;
        if (g >= 0) begin
            q_data.push_back(prod(g));
            q_id.push_back(g);
            rr_m = (g + 1) % NREQ;
            n_m++;
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic do_reset(input int cycles);
        ap_rst    = 1'b1;
        req_valid = '1;
        res_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            #1;
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            @(posedge ap_clk);
            @(negedge ap_clk);
            #1;
            chk("rst_res_valid", 64'(res_valid), 64'(0));
            chk("rst_res_data", 64'(res_data), 64'(0));
            chk("rst_res_id", 64'(res_id), 64'(0));
        end
        ap_rst    = 1'b0;
        req_valid = '0;
        model_clear();
        @(negedge ap_clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[ID_W'(v.id)] = 1'b1;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_a = (req_a & ~(64'hFFFF << (16 * v.id))) | (64'(v.a) << (16 * v.id));
        req_b = (req_b & ~(56'h3FFF << (14 * v.id))) | (56'(v.b) << (14 * v.id));
        req_valid = oh;
        res_ready = 1'b1;
        #1;
        chk("vec_grant", 64'(req_ready), 64'(oh));
        @(posedge ap_clk);
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        chk("vec_lat1_valid", 64'(res_valid), 64'(0));
        @(posedge ap_clk);
        @(negedge ap_clk);
        #1;
        chk("vec_lat2_valid", 64'(res_valid), 64'(1));
        chk("vec_data", 64'(res_data), 64'(v.exp));
        chk("vec_id", 64'(res_id), 64'(v.id));
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    initial begin
        int acc;
        tbl[0] = '{0, 16'h7FFF, 14'h1FFF, 30'h0FFF6001};
        tbl[1] = '{1, 16'h8000, 14'h2000, 30'h10000000};
        tbl[2] = '{2, 16'h8000, 14'h1FFF, 30'(-268402688)};
        tbl[3] = '{3, 16'h0000, 14'h3FFF, 30'h0};
        tbl[4] = '{0, 16'hFFFF, 14'h3FFF, 30'h1};
        tbl[5] = '{1, 16'h0003, 14'h3FFB, 30'(-15)};
        tbl[6] = '{2, 16'h0001, 14'h2000, 30'(-8192)};
        tbl[7] = '{3, 16'h7FFF, 14'h2000, 30'(-268427264)};

        req_a = '0;
        req_b = '0;
        do_reset(2);

        // Directed products with latency check.
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // All requesters continuously valid: ids rotate 0,1,2,3 with one result per cycle.
        do_reset(1);
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_valid = '1;
        res_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                #1;
                chk("rr_res_valid", 64'(res_valid), 64'(1));
                chk("rr_res_id", 64'(res_id), 64'((c - 2) % NREQ));
            end
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 3; c++) step();
        chk("rr_drained", 64'(q_data.size()), 64'(0));

        // Backpressure for 5 cycles: at most two accepts, output frozen.
        do_reset(1);
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_valid = '1;
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ((req_valid & req_ready) != '0) acc++;
            step();
        end
        chk("stall_accepts_le2", 64'(acc <= 2), 64'(1));
        req_valid = '0;
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("stall_drained", 64'(q_data.size()), 64'(0));

        // Reset with both stages full: flushed, first grant goes to lowest valid index.
        do_reset(1);
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_valid = '1;
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) step();
        ap_rst = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        #1;
        chk("midrst_res_valid", 64'(res_valid), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        ap_rst = 1'b0;
        model_clear();
        req_valid = 4'b1010;
        res_ready = 1'b1;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0010));
        for (int c = 0; c < 4; c++) step();
        req_valid = '0;
        for (int c = 0; c < 4; c++) step();
        chk("midrst_drained", 64'(q_data.size()), 64'(0));

        // Random traffic against the model.
        do_reset(1);
        for (int c = 0; c < 500; c++) begin
            req_valid = NREQ'($urandom);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            res_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = '0;
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("rand_drained", 64'(q_data.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
